// File: rtl/execute_stage_md_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, mul/div opcodes,
// forwarding selects and the mul/div sequencer states.
package execute_stage_md_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SLL   = 3'b101,
    ALU_PASSB = 3'b110,
    ALU_ZERO  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIVU = 2'b10,
    MD_REMU = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EM  = 2'b01,
    FWD_MW  = 2'b10,
    FWD_RF2 = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // True when the instruction in EX needs the iterative unit.
  function automatic logic is_md_op(input logic [1:0] op);
    return (op != MD_NONE);
  endfunction

endpackage

// File: rtl/execute_stage_md_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
// master = pipeline driving the stage, slave = the execute stage itself.
interface execute_stage_md_if #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
);
  logic              Stall;
  logic              Flush;
  logic [WIDTH-1:0]  ALUOp1;
  logic [WIDTH-1:0]  ALUOp2;
  logic [WIDTH-1:0]  Immediate;
  logic [1:0]        ForwardALUOp1;
  logic [1:0]        ForwardALUOp2;
  logic [WIDTH-1:0]  PipeEM_Result;
  logic [WIDTH-1:0]  PipeMW_Result;
  logic              ALUSrc;
  logic [2:0]        ALUOpcode;
  logic [1:0]        MDOp;
  logic              MemRead;
  logic              MemWrite;
  logic              MemToReg;
  logic              Halt;
  logic              RegFileWrEn;
  logic [REG_AW-1:0] WriteReg;

  logic              ExBusy;
  logic [WIDTH-1:0]  Address;
  logic [WIDTH-1:0]  WriteData;
  logic              Err;
  logic              MemRead_Out;
  logic              MemWrite_Out;
  logic              MemToReg_Out;
  logic              Halt_Out;
  logic              RegFileWrEn_Out;
  logic [REG_AW-1:0] WriteReg_Out;

  modport master (
    output Stall, Flush, ALUOp1, ALUOp2, Immediate, ForwardALUOp1, ForwardALUOp2,
           PipeEM_Result, PipeMW_Result, ALUSrc, ALUOpcode, MDOp,
           MemRead, MemWrite, MemToReg, Halt, RegFileWrEn, WriteReg,
    input  ExBusy, Address, WriteData, Err, MemRead_Out, MemWrite_Out,
           MemToReg_Out, Halt_Out, RegFileWrEn_Out, WriteReg_Out
  );

  modport slave (
    input  Stall, Flush, ALUOp1, ALUOp2, Immediate, ForwardALUOp1, ForwardALUOp2,
           PipeEM_Result, PipeMW_Result, ALUSrc, ALUOpcode, MDOp,
           MemRead, MemWrite, MemToReg, Halt, RegFileWrEn, WriteReg,
    output ExBusy, Address, WriteData, Err, MemRead_Out, MemWrite_Out,
           MemToReg_Out, Halt_Out, RegFileWrEn_Out, WriteReg_Out
  );
endinterface

// File: rtl/execute_stage_md_md_unit.sv
// Iterative radix-2 multiply / unsigned divide unit.
// MUL uses shift-add (acc = product, quo = multiplier, opb = multiplicand);
// DIVU/REMU use restoring division (acc = remainder, quo = quotient, opb = divisor).
// A zero divisor needs no special casing: the restoring loop naturally yields
// an all-ones quotient and a remainder equal to the dividend.
module md_unit
  import execute_stage_md_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  md_state_e        state;
  logic [CW-1:0]    count;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] opb;
  logic             dz_q;

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] opb_next;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // One radix-2 iteration of whichever operation is latched.
  always_comb begin
    acc_next = acc;
    quo_next = quo;
    opb_next = opb;
    rem_sh   = {acc, quo[WIDTH-1]};
    diff     = rem_sh - {1'b0, opb};
    case (op_q)
      MD_MUL: begin
        acc_next = quo[0] ? (acc + opb) : acc;
        quo_next = {1'b0, quo[WIDTH-1:1]};
        opb_next = {opb[WIDTH-2:0], 1'b0};
      end
      MD_DIVU, MD_REMU: begin
        if (!diff[WIDTH]) begin
          acc_next = diff[WIDTH-1:0];
          quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
          acc_next = rem_sh[WIDTH-1:0];
          quo_next = {quo[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        acc_next = acc;
        quo_next = quo;
      end
    endcase
  end

  // Sequencer: issue latches operands, RUN iterates WIDTH times, DONE waits for commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      count <= '0;
      op_q  <= MD_NONE;
      acc   <= '0;
      quo   <= '0;
      opb   <= '0;
      dz_q  <= 1'b0;
    end else if (abort) begin
      state <= MD_IDLE;
      count <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            op_q  <= op;
            acc   <= '0;
            quo   <= (op == MD_MUL) ? b : a;
            opb   <= (op == MD_MUL) ? a : b;
            dz_q  <= (op != MD_MUL) && (b == '0);
            count <= CNT_INIT;
            state <= MD_RUN;
          end
        end
        MD_RUN: begin
          acc   <= acc_next;
          quo   <= quo_next;
          opb   <= opb_next;
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            state <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (!hold) begin
            state <= MD_IDLE;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  // Result selection from the latched opcode.
  always_comb begin
    case (op_q)
      MD_MUL:  result = acc;
      MD_DIVU: result = quo;
      MD_REMU: result = acc;
      default: result = '0;
    endcase
  end

  assign done = (state == MD_DONE);
  assign dz   = dz_q;

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative mul/div
// and the EX/MEM pipeline register. ExBusy tells the hazard unit to hold
// the front end while a mul/div runs.
module execute_stage_md
  import execute_stage_md_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
) (
  input  logic             clk,
  input  logic             rst,
  execute_stage_md_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0]  address;
    logic [WIDTH-1:0]  write_data;
    logic              err;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              halt;
    logic              reg_wr_en;
    logic [REG_AW-1:0] write_reg;
  } ex_mem_t;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic             md_dz;
  logic             ex_busy;
  ex_mem_t          ex_mem;
  ex_mem_t          ex_mem_next;

  // Forwarding muxes for both operands.
  always_comb begin
    case (bus.ForwardALUOp1)
      FWD_EM:  op_a = bus.PipeEM_Result;
      FWD_MW:  op_a = bus.PipeMW_Result;
      default: op_a = bus.ALUOp1;
    endcase
    case (bus.ForwardALUOp2)
      FWD_EM:  op_b = bus.PipeEM_Result;
      FWD_MW:  op_b = bus.PipeMW_Result;
      default: op_b = bus.ALUOp2;
    endcase
  end

  assign alu_b = bus.ALUSrc ? bus.Immediate : op_b;

  // Single-cycle ALU; shifts use only the low log2(WIDTH) bits of op2.
  always_comb begin
    case (bus.ALUOpcode)
      ALU_ADD:   alu_res = op_a + alu_b;
      ALU_SUB:   alu_res = op_a - alu_b;
      ALU_AND:   alu_res = op_a & alu_b;
      ALU_OR:    alu_res = op_a | alu_b;
      ALU_XOR:   alu_res = op_a ^ alu_b;
      ALU_SLL:   alu_res = op_a << alu_b[SHW-1:0];
      ALU_PASSB: alu_res = alu_b;
      default:   alu_res = '0;
    endcase
  end

  // A stalled stage must not start a new mul/div; Flush aborts through 'abort'.
  assign md_start = is_md_op(bus.MDOp) && !bus.Stall;

  md_unit #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .abort  (bus.Flush),
    .hold   (bus.Stall),
    .op     (bus.MDOp),
    .a      (op_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_result),
    .dz     (md_dz)
  );

  // Busy from the issue cycle until the result is ready to commit.
  assign ex_busy = is_md_op(bus.MDOp) && !md_done;

  // Next EX/MEM contents when the stage actually commits an instruction.
  always_comb begin
    ex_mem_next            = '0;
    ex_mem_next.address    = md_done ? md_result : alu_res;
    ex_mem_next.write_data = op_b;
    ex_mem_next.err        = md_done ? md_dz : 1'b0;
    ex_mem_next.mem_read   = bus.MemRead;
    ex_mem_next.mem_write  = bus.MemWrite;
    ex_mem_next.mem_to_reg = bus.MemToReg;
    ex_mem_next.halt       = bus.Halt;
    ex_mem_next.reg_wr_en  = bus.RegFileWrEn;
    ex_mem_next.write_reg  = bus.WriteReg;
  end

  // EX/MEM register: Flush bubbles (beats Stall), Stall holds, busy bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem <= '0;
    end else if (bus.Flush) begin
      ex_mem <= '0;
    end else if (bus.Stall) begin
      ex_mem <= ex_mem;
    end else if (ex_busy) begin
      ex_mem <= '0;
    end else begin
      ex_mem <= ex_mem_next;
    end
  end

  assign bus.ExBusy          = ex_busy;
  assign bus.Address         = ex_mem.address;
  assign bus.WriteData       = ex_mem.write_data;
  assign bus.Err             = ex_mem.err;
  assign bus.MemRead_Out     = ex_mem.mem_read;
  assign bus.MemWrite_Out    = ex_mem.mem_write;
  assign bus.MemToReg_Out    = ex_mem.mem_to_reg;
  assign bus.Halt_Out        = ex_mem.halt;
  assign bus.RegFileWrEn_Out = ex_mem.reg_wr_en;
  assign bus.WriteReg_Out    = ex_mem.write_reg;

endmodule

// File: tb/tb_execute_stage_md.sv
// Self-checking bench for execute_stage_md: table-driven and random ALU
// vectors, mul/div sequences against an arithmetic reference, and
// flush / stall / reset corner cases; one extra 32-bit instance for MUL.
module tb_execute_stage_md;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  execute_stage_md_if #(.WIDTH(16), .REG_AW(3)) bus16 ();
  execute_stage_md_if #(.WIDTH(32), .REG_AW(3)) bus32 ();

  execute_stage_md #(.WIDTH(16), .REG_AW(3)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  execute_stage_md #(.WIDTH(32), .REG_AW(3)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic        alusrc;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [15:0] em;
    logic [15:0] mw;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [1:0] sel, input logic [15:0] rf,
                                       input logic [15:0] em, input logic [15:0] mw);
    if (sel == 2'b01) return em;
    else if (sel == 2'b10) return mw;
    else return rf;
  endfunction

  // Reference ALU written with plain integer arithmetic modulo 2^16.
  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    longint x, y;
    x = longint'(a);
    y = longint'(b);
    case (op)
      3'd0:    return 16'((x + y) % 65536);
      3'd1:    return 16'((x + 65536 - y) % 65536);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return 16'((x * (longint'(1) << (y % 16))) % 65536);
      3'd6:    return b;
      default: return 16'd0;
    endcase
  endfunction

  // Reference mul/div results.
  function automatic logic [15:0] md_ref(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      2'd1:    return 16'((longint'(a) * longint'(b)) % 65536);
      2'd2:    return (b == 16'd0) ? 16'hFFFF : a / b;
      2'd3:    return (b == 16'd0) ? a : a % b;
      default: return 16'd0;
    endcase
  endfunction

  task automatic idle16();
    bus16.Stall = 1'b0; bus16.Flush = 1'b0;
    bus16.ALUOp1 = 16'd0; bus16.ALUOp2 = 16'd0; bus16.Immediate = 16'd0;
    bus16.ForwardALUOp1 = 2'b00; bus16.ForwardALUOp2 = 2'b00;
    bus16.PipeEM_Result = 16'd0; bus16.PipeMW_Result = 16'd0;
    bus16.ALUSrc = 1'b0; bus16.ALUOpcode = 3'd0; bus16.MDOp = 2'd0;
    bus16.MemRead = 1'b0; bus16.MemWrite = 1'b0; bus16.MemToReg = 1'b0;
    bus16.Halt = 1'b0; bus16.RegFileWrEn = 1'b0; bus16.WriteReg = 3'd0;
  endtask

  task automatic idle32();
    bus32.Stall = 1'b0; bus32.Flush = 1'b0;
    bus32.ALUOp1 = 32'd0; bus32.ALUOp2 = 32'd0; bus32.Immediate = 32'd0;
    bus32.ForwardALUOp1 = 2'b00; bus32.ForwardALUOp2 = 2'b00;
    bus32.PipeEM_Result = 32'd0; bus32.PipeMW_Result = 32'd0;
    bus32.ALUSrc = 1'b0; bus32.ALUOpcode = 3'd0; bus32.MDOp = 2'd0;
    bus32.MemRead = 1'b0; bus32.MemWrite = 1'b0; bus32.MemToReg = 1'b0;
    bus32.Halt = 1'b0; bus32.RegFileWrEn = 1'b0; bus32.WriteReg = 3'd0;
  endtask

  task automatic chk_zero16(input string tag);
    chk({tag, "_addr"}, bus16.Address, 32'd0);
    chk({tag, "_wdata"}, bus16.WriteData, 32'd0);
    chk({tag, "_err"}, bus16.Err, 32'd0);
    chk({tag, "_ctrl"}, {bus16.MemRead_Out, bus16.MemWrite_Out, bus16.MemToReg_Out,
                         bus16.Halt_Out, bus16.RegFileWrEn_Out, bus16.WriteReg_Out}, 32'd0);
  endtask

  // Apply one ALU vector with random passthrough controls and check the commit.
  task automatic apply_alu(input vec_t v);
    logic [4:0] ctrl;
    logic [2:0] wr;
    ctrl = 5'($urandom);
    wr   = 3'($urandom);
    bus16.ALUOpcode = v.op; bus16.ALUOp1 = v.a; bus16.ALUOp2 = v.b;
    bus16.Immediate = v.imm; bus16.ALUSrc = v.alusrc;
    bus16.ForwardALUOp1 = v.f1; bus16.ForwardALUOp2 = v.f2;
    bus16.PipeEM_Result = v.em; bus16.PipeMW_Result = v.mw; bus16.MDOp = 2'd0;
    {bus16.MemRead, bus16.MemWrite, bus16.MemToReg, bus16.Halt, bus16.RegFileWrEn} = ctrl;
    bus16.WriteReg = wr;
    #1;
    chk("alu_busy", bus16.ExBusy, 32'd0);
    tick();
    chk("alu_addr", bus16.Address, v.exp);
    chk("alu_wdata", bus16.WriteData, fwd(v.f2, v.b, v.em, v.mw));
    chk("alu_err", bus16.Err, 32'd0);
    chk("alu_ctrl", {bus16.MemRead_Out, bus16.MemWrite_Out, bus16.MemToReg_Out,
                     bus16.Halt_Out, bus16.RegFileWrEn_Out}, ctrl);
    chk("alu_wreg", bus16.WriteReg_Out, wr);
  endtask

  // Run one mul/div op: count busy cycles, optionally stall in RUN and in DONE.
  task automatic run_md(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit stall_run, input int done_stall);
    int          busy;
    logic [15:0] exp;
    logic        e;
    exp = md_ref(op, a, b);
    e   = (op != 2'd1) && (b == 16'd0);
    bus16.MDOp = op; bus16.ALUOp1 = a; bus16.ALUOp2 = b;
    bus16.ForwardALUOp1 = 2'b00; bus16.ForwardALUOp2 = 2'b11;
    bus16.ALUSrc = 1'b1; bus16.Immediate = 16'($urandom); bus16.ALUOpcode = 3'($urandom);
    bus16.RegFileWrEn = 1'b1; bus16.WriteReg = 3'd5;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      bus16.Stall = stall_run && (i >= 3) && (i <= 5);
      #1;
      if (!bus16.ExBusy) break;
      busy++;
      tick();
    end
    bus16.Stall = 1'b0;
    chk("md_busy_cycles", busy, 32'd17);
    chk("md_bubble_wen", bus16.RegFileWrEn_Out, 32'd0);
    bus16.Stall = (done_stall > 0);
    repeat (done_stall) begin
      tick();
      chk("done_stall_busy", bus16.ExBusy, 32'd0);
      chk("done_stall_addr", bus16.Address, 32'd0);
      chk("done_stall_wen", bus16.RegFileWrEn_Out, 32'd0);
    end
    bus16.Stall = 1'b0;
    tick();
    chk("md_result", bus16.Address, exp);
    chk("md_err", bus16.Err, e);
    chk("md_wen", bus16.RegFileWrEn_Out, 32'd1);
    chk("md_wreg", bus16.WriteReg_Out, 32'd5);
    chk("md_wdata", bus16.WriteData, b);
    bus16.MDOp = 2'd0; bus16.RegFileWrEn = 1'b0;
    tick();
    chk("md_single_write", bus16.RegFileWrEn_Out, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          busy32;
    logic [1:0]  rop;
    logic [15:0] ra, rb;
    vec_t        rv;

    idle16();
    idle32();
    rst = 1'b1;
    tick();
    tick();
    chk_zero16("reset");
    chk("reset_busy", bus16.ExBusy, 32'd0);
    rst = 1'b0;

    //          op    a         b         imm       src   f1     f2     em        mw        exp
    vecs[0] = '{3'd0, 16'h1111, 16'h0003, 16'h0000, 1'b0, 2'b01, 2'b00, 16'h0005, 16'h0000, 16'h0008};
    vecs[1] = '{3'd1, 16'h0003, 16'h0005, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'hFFFE};
    vecs[2] = '{3'd2, 16'hF0F0, 16'h1234, 16'h0FF0, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h00F0};
    vecs[3] = '{3'd5, 16'h0001, 16'h000F, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h8000};
    vecs[4] = '{3'd5, 16'h0001, 16'h0013, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0008};
    vecs[5] = '{3'd3, 16'h00A0, 16'h5555, 16'h0000, 1'b0, 2'b00, 2'b10, 16'h0000, 16'h0A00, 16'h0AA0};
    vecs[6] = '{3'd4, 16'hFFFF, 16'h0F0F, 16'h0000, 1'b0, 2'b11, 2'b11, 16'h1111, 16'h2222, 16'hF0F0};
    vecs[7] = '{3'd6, 16'h1234, 16'h0001, 16'hBEEF, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'hBEEF};
    vecs[8] = '{3'd7, 16'h1234, 16'h4321, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000};
    vecs[9] = '{3'd0, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0001};
    for (int i = 0; i < 10; i++) apply_alu(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      rv.op = 3'($urandom); rv.a = 16'($urandom); rv.b = 16'($urandom);
      rv.imm = 16'($urandom); rv.alusrc = 1'($urandom);
      rv.f1 = 2'($urandom); rv.f2 = 2'($urandom);
      rv.em = 16'($urandom); rv.mw = 16'($urandom);
      rv.exp = alu_ref(rv.op, fwd(rv.f1, rv.a, rv.em, rv.mw),
                       rv.alusrc ? rv.imm : fwd(rv.f2, rv.b, rv.em, rv.mw));
      apply_alu(rv);
    end

    // Directed mul/div cases.
    run_md(2'd1, 16'h0123, 16'h0010, 1'b0, 0);
    run_md(2'd2, 16'h0064, 16'h0007, 1'b0, 0);
    run_md(2'd3, 16'h0064, 16'h0007, 1'b0, 0);
    run_md(2'd2, 16'h1234, 16'h0000, 1'b0, 0);
    run_md(2'd3, 16'h1234, 16'h0000, 1'b0, 0);
    run_md(2'd1, 16'hFFFF, 16'hFFFF, 1'b1, 0);

    // Stall held 3 cycles in DONE.
    run_md(2'd1, 16'h0123, 16'h0010, 1'b0, 3);

    // Random mul/div against the reference.
    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(1, 3));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
      run_md(rop, ra, rb, 1'($urandom), 0);
    end

    // Stall alone holds EX/MEM; Flush beats Stall.
    idle16();
    bus16.ALUOpcode = 3'd0; bus16.ALUOp1 = 16'd2; bus16.ALUOp2 = 16'd3; bus16.RegFileWrEn = 1'b1;
    tick();
    chk("add_before_stall", bus16.Address, 32'd5);
    bus16.ALUOp1 = 16'd9; bus16.Stall = 1'b1;
    tick();
    chk("stall_hold_addr", bus16.Address, 32'd5);
    chk("stall_hold_wen", bus16.RegFileWrEn_Out, 32'd1);
    bus16.Flush = 1'b1;
    tick();
    chk_zero16("flush_over_stall");
    idle16();

    // Flush in RUN cycle 5, then a normal ADD and a fresh full-length MUL.
    bus16.MDOp = 2'd1; bus16.ALUOp1 = 16'h0123; bus16.ALUOp2 = 16'h0010; bus16.RegFileWrEn = 1'b1;
    tick();
    repeat (4) tick();
    bus16.Flush = 1'b1;
    #1;
    chk("flush_busy_before", bus16.ExBusy, 32'd1);
    tick();
    idle16();
    #1;
    chk("flush_busy_after", bus16.ExBusy, 32'd0);
    chk_zero16("flush_bubble");
    bus16.ALUOpcode = 3'd0; bus16.ALUOp1 = 16'd7; bus16.ALUOp2 = 16'd6; bus16.RegFileWrEn = 1'b1;
    tick();
    chk("post_flush_add", bus16.Address, 32'd13);
    chk("post_flush_wen", bus16.RegFileWrEn_Out, 32'd1);
    run_md(2'd1, 16'h0101, 16'h0003, 1'b0, 0);

    // Reset in the middle of RUN.
    idle16();
    bus16.MDOp = 2'd3; bus16.ALUOp1 = 16'h4321; bus16.ALUOp2 = 16'h0011; bus16.RegFileWrEn = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero16("rst_mid_run");
    run_md(2'd3, 16'h4321, 16'h0011, 1'b0, 0);

    // 32-bit instance: MUL 0x10000 * 0x10.
    bus32.MDOp = 2'd1; bus32.ALUOp1 = 32'h0001_0000; bus32.ALUOp2 = 32'h0000_0010;
    bus32.RegFileWrEn = 1'b1;
    busy32 = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus32.ExBusy) break;
      busy32++;
      tick();
    end
    chk("w32_busy_cycles", busy32, 32'd33);
    tick();
    chk("w32_mul", bus32.Address, 32'h0010_0000);
    chk("w32_wen", bus32.RegFileWrEn_Out, 32'd1);
    idle32();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
